// File: rtl/median_stream.sv
// median_stream: streaming 3x3 rank filter (median / min / max / pass-through).
// Raster pixels enter one per accepted cycle. Two line buffers and a 3x3 shift
// register build each window. A 3-stage sorting network and an output register
// give a fixed 4-cycle latency from the window-completing pixel to valid_o.
module median_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240
) (
    input  logic              clk_i_median_stream,
    input  logic              rst_i_median_stream,
    input  logic              en_i_median_stream,
    input  logic              valid_i,
    input  logic              sof_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_done_o,
    output logic              ovf_o
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [1:0] {
        MODE_MEDIAN = 2'b00,
        MODE_MIN    = 2'b01,
        MODE_MAX    = 2'b10,
        MODE_PASS   = 2'b11
    } mode_t;

    // Unsigned compare helpers; all results stay DATA_W wide.
    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Position / frame control
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              complete_q;
    mode_t             mode_q;

    logic              accept;
    logic              take;
    logic              last_col;
    logic              last_row;
    logic              window_done;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;

    // Line buffers and window
    logic [DATA_W-1:0] buf0 [IMG_W];
    logic [DATA_W-1:0] buf1 [IMG_W];
    logic [DATA_W-1:0] win  [3][3];   // [row][col], row 2 / col 2 newest

    // Sorting network data
    logic [DATA_W-1:0] s1_lo  [3];
    logic [DATA_W-1:0] s1_mid [3];
    logic [DATA_W-1:0] s1_hi  [3];
    logic [DATA_W-1:0] s1_centre;
    logic [DATA_W-1:0] s2_lo_max;
    logic [DATA_W-1:0] s2_mid_med;
    logic [DATA_W-1:0] s2_hi_min;
    logic [DATA_W-1:0] s2_min;
    logic [DATA_W-1:0] s2_max;
    logic [DATA_W-1:0] s2_centre;
    logic [DATA_W-1:0] s3_data;

    // Per-stage tags travelling alongside the data
    logic  win_v, s1_v, s2_v, s3_v;
    logic  win_last, s1_last, s2_last, s3_last;
    mode_t win_mode, s1_mode, s2_mode;

    // Current pixel position, acceptance decode and line-buffer read.
    // NOTE: every always_comb output gets a value on every path (here unconditionally), otherwise a latch is inferred.
    always_comb begin
        accept      = en_i_median_stream && valid_i;
        cur_col     = sof_i ? '0 : col_q;
        cur_row     = sof_i ? '0 : row_q;
        last_col    = (cur_col == COL_LAST);
        last_row    = (cur_row == ROW_LAST);
        take        = accept && (sof_i || !complete_q);
        window_done = take && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
        rd0         = buf0[cur_col];
        rd1         = buf1[cur_col];
    end

    // Column/row counters, frame-complete flag, latched mode and sticky overflow.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i_median_stream or posedge rst_i_median_stream) begin
        if (rst_i_median_stream) begin
            col_q      <= '0;
            row_q      <= '0;
            complete_q <= 1'b0;
            mode_q     <= MODE_MEDIAN;
            ovf_o      <= 1'b0;
        end else if (accept) begin
            if (sof_i) begin
                mode_q <= mode_t'(mode_i);
                ovf_o  <= 1'b0;
            end
            if (take) begin
                complete_q <= last_col && last_row;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : cur_row + ROW_W'(1);
                end else begin
                    col_q <= cur_col + COL_W'(1);
                    row_q <= cur_row;
                end
            end else begin
                ovf_o <= 1'b1;
            end
        end
    end

    // Line buffers: buf0 holds the previous row, buf1 the row before that.
    // NOTE: the buffers have no reset; windows only form from rows written in the current frame.
    always_ff @(posedge clk_i_median_stream) begin
        if (take) begin
            buf1[cur_col] <= rd0;
            buf0[cur_col] <= data_i;
        end
    end

    // 3x3 window shift register: new right column {buf1, buf0, data_i}.
    always_ff @(posedge clk_i_median_stream) begin
        if (take) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= rd1;
            win[1][2] <= rd0;
            win[2][2] <= data_i;
        end
    end

    // Stage 1: sort each window row.
    always_ff @(posedge clk_i_median_stream) begin
        for (int r = 0; r < 3; r++) begin
            s1_lo[r]  <= min3(win[r][0], win[r][1], win[r][2]);
            s1_mid[r] <= med3(win[r][0], win[r][1], win[r][2]);
            s1_hi[r]  <= max3(win[r][0], win[r][1], win[r][2]);
        end
        s1_centre <= win[1][1];
    end

    // Stage 2: median candidates plus overall min/max and the carried centre.
    always_ff @(posedge clk_i_median_stream) begin
        s2_lo_max  <= max3(s1_lo[0], s1_lo[1], s1_lo[2]);
        s2_mid_med <= med3(s1_mid[0], s1_mid[1], s1_mid[2]);
        s2_hi_min  <= min3(s1_hi[0], s1_hi[1], s1_hi[2]);
        s2_min     <= min3(s1_lo[0], s1_lo[1], s1_lo[2]);
        s2_max     <= max3(s1_hi[0], s1_hi[1], s1_hi[2]);
        s2_centre  <= s1_centre;
    end

    // Stage 3: final median and mode selection.
    always_ff @(posedge clk_i_median_stream) begin
        case (s2_mode)
            MODE_MEDIAN: s3_data <= med3(s2_lo_max, s2_mid_med, s2_hi_min);
            MODE_MIN:    s3_data <= s2_min;
            MODE_MAX:    s3_data <= s2_max;
            default:     s3_data <= s2_centre;
        endcase
    end

    // Valid/last/mode tags and the output register; cleared asynchronously by reset.
    always_ff @(posedge clk_i_median_stream or posedge rst_i_median_stream) begin
        if (rst_i_median_stream) begin
            win_v        <= 1'b0;
            s1_v         <= 1'b0;
            s2_v         <= 1'b0;
            s3_v         <= 1'b0;
            win_last     <= 1'b0;
            s1_last      <= 1'b0;
            s2_last      <= 1'b0;
            s3_last      <= 1'b0;
            win_mode     <= MODE_MEDIAN;
            s1_mode      <= MODE_MEDIAN;
            s2_mode      <= MODE_MEDIAN;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
            data_o       <= '0;
        end else begin
            win_v        <= window_done;
            win_last     <= window_done && last_col && last_row;
            win_mode     <= mode_q;
            s1_v         <= win_v;
            s1_last      <= win_last;
            s1_mode      <= win_mode;
            s2_v         <= s1_v;
            s2_last      <= s1_last;
            s2_mode      <= s1_mode;
            s3_v         <= s2_v;
            s3_last      <= s2_last;
            valid_o      <= s3_v;
            frame_done_o <= s3_v && s3_last;
            if (s3_v) begin
                data_o <= s3_data;
            end
        end
    end

endmodule

// File: doc/median_stream.md
# median_stream

Streaming, parametrised 3x3 rank filter for the image-processing chain. It accepts one raster-order pixel per valid cycle and builds each 3x3 window internally from two line buffers, so the caller no longer assembles windows. A fixed-latency pipelined sorting network then produces one result per interior pixel. Supported ranks are median, min and max, plus a pass-through mode for bypass. Output count and order per frame are (IMG_W-2)*(IMG_H-2) in raster order, matching the existing software reference dumps.

## Interface
- DATA_W, 8: pixel width in bits (unsigned).
- IMG_W, 320: frame width in pixels; must be at least 3.
- IMG_H, 240: frame height in pixels; must be at least 3.
- clk_i_median_stream  in  1  single clock; all logic is on the rising edge.
- rst_i_median_stream  in  1  reset, asynchronous, active-high.
- en_i_median_stream  in  1  input enable; when 0, valid_i is ignored and the pipeline still drains.
- valid_i  in  1  data_i carries a pixel this cycle.
- sof_i  in  1  qualified by valid_i; marks the current pixel as (row 0, col 0).
- mode_i  in  2  operation select: 00 median, 01 min, 10 max, 11 centre pass-through. Sampled on the sof_i pixel.
- data_i  in  DATA_W  input pixel.
- data_o  out  DATA_W  filter result.
- valid_o  out  1  data_o is valid this cycle.
- frame_done_o  out  1  one-cycle pulse coincident with the last valid_o of a frame.
- ovf_o  out  1  sticky flag: a pixel arrived after the frame was complete. Cleared by sof_i.

## Operation
- Accepted pixel: a cycle with en_i_median_stream=1 and valid_i=1.
- Counters:
  - col runs 0..IMG_W-1 and wraps to 0, incrementing row.
  - row runs 0..IMG_H-1.
  - An accepted pixel with sof_i=1 loads col=0, row=0 for that pixel.
- Line buffers:
  - Two IMG_W x DATA_W memories, addressed by col.
  - On each accepted pixel, buf1[col] is written with buf0[col], and buf0[col] with data_i.
  - Buffer contents are not reset; windows only form from freshly written rows.
- Window:
  - A 3x3 shift register takes {buf1[col], buf0[col], data_i} as its new right column.
  - The window is complete when the accepted pixel has row>=2 and col>=2. It is then centred on (row-1, col-1).
  - Windows spanning a row wrap (col<2) never produce output.
- Sorting network, median mode:
  - Stage 1: sort each row of 3.
  - Stage 2: take the max of the row-mins, the median of the row-medians, and the min of the row-maxes.
  - Stage 3: median of those three values.
  - Min and max modes use the stage-1 row mins and maxes.
  - Pass-through outputs the centre pixel through the same stages, so latency is unchanged.
- All comparisons are unsigned and DATA_W wide; there is no arithmetic growth.
- The mode is latched at sof and applies to the whole frame. A mode_i change mid-frame has no effect.
- Frame end: the accepted pixel (IMG_H-1, IMG_W-1) completes the last window. Its output asserts frame_done_o.
- Overflow: accepted pixels after the frame is complete and before the next sof_i are ignored (no buffer write, no output) and set ovf_o.
- sof_i mid-frame: counters restart immediately. Results already in the pipeline still emerge; no flush.

## Timing
- Reset values: data_o=0, valid_o=0, frame_done_o=0, ovf_o=0, counters 0, pipeline valid tags 0, latched mode=00.
- Latency is fixed at 4 cycles. If the window-completing pixel is accepted on edge T, valid_o is high in the cycle after edge T+4, i.e. the stages are window, stage 1, stage 2, stage 3 then output register.
- The pipeline advances every cycle, independent of valid_i. Gaps shift outputs but never change latency.
- Throughput is one result per clock, with no backpressure.
- valid_o is high for exactly one cycle per completed window.
- Asserting reset mid-operation clears all in-flight valid tags within the same cycle (asynchronous). No stale valid_o appears after reset is released.

## Test plan
- IMG_W=4, IMG_H=4, median mode, ramp 0..15 with back-to-back valid_i -> data_o 5, 6, 9, 10. Each appears 4 cycles after pixels 10, 11, 14, 15 respectively. frame_done_o pulses with the output of 10.
- Same ramp in min mode -> 0, 1, 4, 5. In max mode -> 10, 11, 14, 15. In pass-through -> 5, 6, 9, 10.
- 4x4 frame of all 50 with 255 at (1,1):
  - median mode -> four outputs of 50.
  - max mode -> 255, 255, 255, 255, since every window contains (1,1).
- Ramp 0..15 with random 0-3 idle cycles between pixels -> same values 5, 6, 9, 10, each still exactly 4 cycles after its completing pixel.
- Reset asserted after pixel 11, then a fresh sof ramp -> outputs 0 during and after reset with no stray valid_o. The new frame yields 5, 6, 9, 10.
- 17 pixels sent with sof on the first -> four outputs as normal. Pixel 17 is ignored and ovf_o=1 until the next sof_i pixel, which clears it.
